// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared serial link encodings and defaults
package serial_link_pkg;

   // Payload width shared by the transmitter and the matching receiver.
   localparam int DEFAULT_DATA_W = 8;

   // Line levels: idle/guard level and the frame start marker.
   localparam logic LINE_IDLE  = 1'b0;
   localparam logic START_MARK = 1'b1;

   // Transmitter FSM encoding.
   typedef logic [2:0] tx_state_t;
   localparam tx_state_t ST_IDLE   = 3'd0;
   localparam tx_state_t ST_START  = 3'd1;
   localparam tx_state_t ST_DATA   = 3'd2;
   localparam tx_state_t ST_PARITY = 3'd3;
   localparam tx_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/tx_shift_unit.sv
// rtl/tx_shift_unit.sv - payload load/shift register with data bit counter
module tx_shift_unit
   import serial_link_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic              advance_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              bit_out,
   output logic              last_bit
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // cnt_q is the index of the payload bit currently on the line; it stops
   // at DATA_W-1 so it never wraps.
   assign bit_out  = shreg_q[0];
   assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

   // Next-state: load on acceptance, shift as each bit is launched.
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         shreg_d = data_i;
         cnt_d   = '0;
      end else begin
         if (shift_i) begin
            shreg_d = shreg_q >> 1;
         end
         if (advance_i && !last_bit) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_frame_transmitter.sv
// rtl/serial_frame_transmitter.sv - framed serial transmitter, optional parity via SERIAL_TX_PARITY_EN
module serial_frame_transmitter
   import serial_link_pkg::*;
#(
   parameter int DATA_W      = DEFAULT_DATA_W,
   parameter int STOP_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              send,
   output logic              ready,
   output logic              serial_out,
   output logic              busy,
   output logic              done
);

   localparam int STOP_W = $clog2(STOP_CYCLES + 1);

   tx_state_t         state_q, state_d;
   logic              serial_out_q, serial_out_d;
   logic              done_q, done_d;
   logic [STOP_W-1:0] stop_cnt_q, stop_cnt_d;
   logic              accept;
   logic              bit_out;
   logic              last_bit;
   logic              stop_last;
`ifdef SERIAL_TX_PARITY_EN
   logic              parity_q;
`endif

   assign accept     = (state_q == ST_IDLE) && send;
   assign stop_last  = (stop_cnt_q == STOP_W'(STOP_CYCLES - 1));
   assign ready      = (state_q == ST_IDLE);
   assign busy       = !ready;
   assign serial_out = serial_out_q;
   assign done       = done_q;

   // A bit is shifted out on the edge that puts it on the line, so bit_out
   // always holds the next payload bit to launch.
   tx_shift_unit #(
      .DATA_W (DATA_W)
   ) u_shift (
      .clk       (clk),
      .rst       (rst),
      .load_i    (accept),
      .shift_i   ((state_q == ST_START) || ((state_q == ST_DATA) && !last_bit)),
      .advance_i (state_q == ST_DATA),
      .data_i    (data_in),
      .bit_out   (bit_out),
      .last_bit  (last_bit)
   );

   // FSM next state; the line value is computed for the state being entered
   // so serial_out and done come straight from flops.
   always_comb begin
      state_d      = state_q;
      stop_cnt_d   = stop_cnt_q;
      done_d       = 1'b0;
      serial_out_d = LINE_IDLE;
      case (state_q)
         ST_IDLE: begin
            if (send) begin
               state_d      = ST_START;
               serial_out_d = START_MARK;
            end
         end
         ST_START: begin
            state_d      = ST_DATA;
            serial_out_d = bit_out;
         end
         ST_DATA: begin
            if (!last_bit) begin
               serial_out_d = bit_out;
            end else begin
`ifdef SERIAL_TX_PARITY_EN
               state_d      = ST_PARITY;
               serial_out_d = parity_q;
`else
               state_d    = ST_STOP;
               stop_cnt_d = '0;
               done_d     = (STOP_CYCLES == 1);
`endif
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         ST_PARITY: begin
            state_d    = ST_STOP;
            stop_cnt_d = '0;
            done_d     = (STOP_CYCLES == 1);
         end
`endif
         ST_STOP: begin
            if (stop_last) begin
               state_d = ST_IDLE;
            end else begin
               stop_cnt_d = stop_cnt_q + 1'b1;
               done_d     = (stop_cnt_d == STOP_W'(STOP_CYCLES - 1));
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered FSM, line and stop counter; reset abandons any partial frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         serial_out_q <= LINE_IDLE;
         done_q       <= 1'b0;
         stop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         serial_out_q <= serial_out_d;
         done_q       <= done_d;
         stop_cnt_q   <= stop_cnt_d;
      end
   end

`ifdef SERIAL_TX_PARITY_EN
   // Even parity of the accepted word, captured once at acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else if (accept) begin
         parity_q <= ^data_in;
      end
   end
`endif

endmodule
